// File: rtl/id_control_stage_if.sv
// ID-stage decode bus: IF/ID instruction fields in, ID/EX control fields out.
interface id_control_stage_if #(
    parameter int CMD_W = 4
);
    logic             i_Valid;
    logic [3:0]       i_Cond;
    logic [1:0]       i_Mode;
    logic [3:0]       i_Opcode;
    logic             i_S;
    logic             i_Immediate;
    logic             i_Mul_Ins;
    logic [3:0]       i_Status;
    logic             i_Hazard_Stall;
    logic             i_Flush;
    logic [CMD_W-1:0] o_Sigs_Control;
    logic             o_Sig_Memory_Write_Enable;
    logic             o_Sig_Memory_Read_Enable;
    logic             o_Sig_Write_Back_Enable;
    logic             o_Sig_Status_Write_Enable;
    logic             o_Sig_Branch_Taken;
    logic             o_Immediate;
    logic             o_Valid;
    logic             o_Stall_Request;
    logic             o_Mul_Busy;

    modport master (
        output i_Valid, i_Cond, i_Mode, i_Opcode, i_S, i_Immediate, i_Mul_Ins,
               i_Status, i_Hazard_Stall, i_Flush,
        input  o_Sigs_Control, o_Sig_Memory_Write_Enable, o_Sig_Memory_Read_Enable,
               o_Sig_Write_Back_Enable, o_Sig_Status_Write_Enable, o_Sig_Branch_Taken,
               o_Immediate, o_Valid, o_Stall_Request, o_Mul_Busy
    );

    modport slave (
        input  i_Valid, i_Cond, i_Mode, i_Opcode, i_S, i_Immediate, i_Mul_Ins,
               i_Status, i_Hazard_Stall, i_Flush,
        output o_Sigs_Control, o_Sig_Memory_Write_Enable, o_Sig_Memory_Read_Enable,
               o_Sig_Write_Back_Enable, o_Sig_Status_Write_Enable, o_Sig_Branch_Taken,
               o_Immediate, o_Valid, o_Stall_Request, o_Mul_Busy
    );
endinterface

// File: rtl/id_control_stage.sv
// Registered ARM decode stage: condition-gated control fields plus a MUL
// sequencer that freezes the front end while MUL occupies EX.
//   state | meaning
//   IDLE  | decoding one instruction per cycle
//   BUSY  | MUL in EX; outputs held, front end frozen until last cycle
module id_control_stage #(
    parameter int CMD_W      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int ENABLE_MUL = 1
) (
    input logic               i_Clock,
    input logic               i_Reset,
    id_control_stage_if.slave bus
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CMD_W-1:0] CMD_MUL  = CMD_W'(4'b1010);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_s_q;
    logic [CMD_W-1:0] cmd_q;
    logic             mem_w_q, mem_r_q, wb_q, status_w_q, branch_q;
    logic             imm_q, valid_q, stall_q, busy_q;

    logic [CMD_W-1:0] dec_cmd;
    logic             dec_wb, dec_mr, dec_mw, dec_sw, dec_br;
    logic             is_mul, cond_pass;
    logic             n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = bus.i_Status;
    assign is_mul = (ENABLE_MUL != 0) && bus.i_Mul_Ins && (bus.i_Mode == 2'b00);

    always_comb begin
        cond_pass = 1'b0;
        case (bus.i_Cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Ungated decode; the condition check is applied when registering.
    always_comb begin
        dec_cmd = '0;
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_sw  = 1'b0;
        dec_br  = 1'b0;
        case (bus.i_Mode)
            2'b00: begin
                if (is_mul) begin
                    dec_cmd = CMD_MUL;
                end else begin
                    case (bus.i_Opcode)
                        4'b1101: begin dec_cmd = CMD_W'(4'b0001); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b1111: begin dec_cmd = CMD_W'(4'b1001); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b0100: begin dec_cmd = CMD_W'(4'b0010); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b0101: begin dec_cmd = CMD_W'(4'b0011); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b0010: begin dec_cmd = CMD_W'(4'b0100); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b0110: begin dec_cmd = CMD_W'(4'b0101); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b0000: begin dec_cmd = CMD_W'(4'b0110); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b1100: begin dec_cmd = CMD_W'(4'b0111); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b0001: begin dec_cmd = CMD_W'(4'b1000); dec_wb = 1'b1; dec_sw = bus.i_S; end
                        4'b1010: begin dec_cmd = CMD_W'(4'b0100); dec_sw = 1'b1; end
                        4'b1000: begin dec_cmd = CMD_W'(4'b0110); dec_sw = 1'b1; end
                        default: ;
                    endcase
                end
            end
            2'b01: begin
                dec_cmd = CMD_W'(4'b0010);
                if (bus.i_S) begin
                    dec_mr = 1'b1;
                    dec_wb = 1'b1;
                end else begin
                    dec_mw = 1'b1;
                end
            end
            2'b10: dec_br = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset || bus.i_Flush ||
            (state_q == IDLE && (bus.i_Hazard_Stall || !bus.i_Valid))) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mul_s_q    <= 1'b0;
            cmd_q      <= '0;
            mem_w_q    <= 1'b0;
            mem_r_q    <= 1'b0;
            wb_q       <= 1'b0;
            status_w_q <= 1'b0;
            branch_q   <= 1'b0;
            imm_q      <= 1'b0;
            valid_q    <= 1'b0;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else if (state_q == BUSY) begin
            if (cnt_q == CNT_LAST) begin
                wb_q       <= 1'b1;
                status_w_q <= mul_s_q;
                stall_q    <= 1'b0;
                busy_q     <= 1'b0;
                state_q    <= IDLE;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (is_mul && cond_pass) begin
            state_q    <= BUSY;
            cnt_q      <= CNT_W'(1);
            mul_s_q    <= bus.i_S;
            cmd_q      <= CMD_MUL;
            mem_w_q    <= 1'b0;
            mem_r_q    <= 1'b0;
            wb_q       <= 1'b0;
            status_w_q <= 1'b0;
            branch_q   <= 1'b0;
            imm_q      <= bus.i_Immediate;
            valid_q    <= 1'b1;
            stall_q    <= 1'b1;
            busy_q     <= 1'b1;
        end else begin
            cmd_q      <= dec_cmd;
            mem_w_q    <= dec_mw & cond_pass;
            mem_r_q    <= dec_mr & cond_pass;
            wb_q       <= dec_wb & cond_pass;
            status_w_q <= dec_sw & cond_pass;
            branch_q   <= dec_br & cond_pass;
            imm_q      <= bus.i_Immediate;
            valid_q    <= 1'b1;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
        end
    end

    assign bus.o_Sigs_Control            = cmd_q;
    assign bus.o_Sig_Memory_Write_Enable = mem_w_q;
    assign bus.o_Sig_Memory_Read_Enable  = mem_r_q;
    assign bus.o_Sig_Write_Back_Enable   = wb_q;
    assign bus.o_Sig_Status_Write_Enable = status_w_q;
    assign bus.o_Sig_Branch_Taken        = branch_q;
    assign bus.o_Immediate               = imm_q;
    assign bus.o_Valid                   = valid_q;
    assign bus.o_Stall_Request           = stall_q;
    assign bus.o_Mul_Busy                = busy_q;
endmodule

// File: tb/tb_id_control_stage.sv
// Scoreboard bench for id_control_stage: each driven cycle pushes its expected
// output vector, which is popped and compared one clock later.
module tb_id_control_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [12:0] exp_q[$];

    id_control_stage_if #(.CMD_W(4)) bus_if ();

    id_control_stage #(.CMD_W(4), .MUL_CYCLES(3), .ENABLE_MUL(1)) dut (
        .i_Clock (clk),
        .i_Reset (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // {cmd[3:0], memw, memr, wb, statusw, branch, imm, valid, stall, busy}
    logic [12:0] dut_vec;
    assign dut_vec = {bus_if.o_Sigs_Control, bus_if.o_Sig_Memory_Write_Enable,
                      bus_if.o_Sig_Memory_Read_Enable, bus_if.o_Sig_Write_Back_Enable,
                      bus_if.o_Sig_Status_Write_Enable, bus_if.o_Sig_Branch_Taken,
                      bus_if.o_Immediate, bus_if.o_Valid, bus_if.o_Stall_Request,
                      bus_if.o_Mul_Busy};

    function automatic logic [12:0] mk(input logic [3:0] cmd, input logic mw, input logic mr,
                                       input logic wb, input logic sw, input logic br,
                                       input logic imm, input logic v, input logic st,
                                       input logic bz);
        return {cmd, mw, mr, wb, sw, br, imm, v, st, bz};
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic drv(input logic v, input logic [3:0] cond, input logic [1:0] mode,
                       input logic [3:0] op, input logic s, input logic imm, input logic mul,
                       input logic [3:0] st, input logic hz, input logic fl);
        bus_if.i_Valid        = v;
        bus_if.i_Cond         = cond;
        bus_if.i_Mode         = mode;
        bus_if.i_Opcode       = op;
        bus_if.i_S            = s;
        bus_if.i_Immediate    = imm;
        bus_if.i_Mul_Ins      = mul;
        bus_if.i_Status       = st;
        bus_if.i_Hazard_Stall = hz;
        bus_if.i_Flush        = fl;
    endtask

    task automatic run(input string tag, input logic [12:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk(tag, dut_vec, exp_q.pop_front());
    endtask

    localparam logic [12:0] ZERO = 13'b0;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        run("reset", ZERO);

        // MUL aborted by a 2-cycle reset, then ADD decodes normally
        rst_n = 1'b1;
        drv(1, 4'hE, 2'b00, 4'h0, 0, 0, 1, 4'h0, 0, 0);
        run("mul_enter", mk(4'hA, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        rst_n = 1'b0;
        drv(1, 4'hE, 2'b00, 4'h4, 0, 0, 0, 4'h0, 0, 0);
        run("mid_reset1", ZERO);
        run("mid_reset2", ZERO);
        rst_n = 1'b1;
        run("add_after_reset", mk(4'h2, 0, 0, 1, 0, 0, 0, 1, 0, 0));

        drv(1, 4'hE, 2'b00, 4'hA, 0, 0, 0, 4'h0, 0, 0);
        run("cmp", mk(4'h4, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        drv(1, 4'h0, 2'b00, 4'h4, 0, 0, 0, 4'h0, 0, 0);
        run("addeq_fail", mk(4'h2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drv(1, 4'h0, 2'b00, 4'h4, 0, 0, 0, 4'h4, 0, 0);
        run("addeq_pass", mk(4'h2, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        drv(1, 4'hE, 2'b00, 4'hF, 1, 1, 0, 4'h0, 0, 0);
        run("mvns_imm", mk(4'h9, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        drv(1, 4'hE, 2'b00, 4'h8, 0, 0, 0, 4'h0, 0, 0);
        run("tst", mk(4'h6, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        drv(1, 4'hE, 2'b00, 4'h3, 1, 0, 0, 4'h0, 0, 0);
        run("nop_opcode", mk(4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drv(1, 4'hF, 2'b00, 4'h4, 1, 0, 0, 4'hF, 0, 0);
        run("cond_never", mk(4'h2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drv(1, 4'hE, 2'b01, 4'h0, 1, 1, 0, 4'h0, 0, 0);
        run("ldr", mk(4'h2, 0, 1, 1, 0, 0, 1, 1, 0, 0));
        drv(1, 4'hE, 2'b01, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        run("str", mk(4'h2, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        drv(1, 4'hC, 2'b10, 4'h0, 0, 0, 0, 4'h9, 0, 0);
        run("bgt_pass", mk(4'h0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        drv(1, 4'hC, 2'b10, 4'h0, 0, 0, 0, 4'h8, 0, 0);
        run("bgt_fail", mk(4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drv(1, 4'hE, 2'b11, 4'h4, 1, 0, 0, 4'h0, 0, 0);
        run("coproc", mk(4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // full MUL with S=1; next instruction held on IF/ID meanwhile
        drv(1, 4'hE, 2'b00, 4'h0, 1, 0, 1, 4'h0, 0, 0);
        run("muls_c1", mk(4'hA, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        drv(1, 4'hE, 2'b00, 4'h4, 1, 0, 0, 4'h0, 0, 0);
        run("muls_c2", mk(4'hA, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        run("muls_c3", mk(4'hA, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        run("after_mul", mk(4'h2, 0, 0, 1, 1, 0, 0, 1, 0, 0));

        // flush in the 2nd MUL cycle
        drv(1, 4'hE, 2'b00, 4'h0, 1, 0, 1, 4'h0, 0, 0);
        run("mulf_c1", mk(4'hA, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        drv(1, 4'hE, 2'b00, 4'h0, 1, 0, 1, 4'h0, 0, 1);
        run("mul_flush", ZERO);
        drv(0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        run("post_flush_idle", ZERO);

        drv(1, 4'hE, 2'b00, 4'h4, 0, 0, 0, 4'h0, 1, 1);
        run("flush_and_hazard", ZERO);
        drv(1, 4'hE, 2'b00, 4'h4, 0, 0, 0, 4'h0, 1, 0);
        run("hazard_bubble", ZERO);
        drv(0, 4'hE, 2'b00, 4'h4, 0, 0, 0, 4'h0, 0, 0);
        run("invalid_bubble", ZERO);

        // MUL whose condition fails: single slot, no sequencer entry
        drv(1, 4'h0, 2'b00, 4'h0, 1, 0, 1, 4'h0, 0, 0);
        run("mul_cond_fail", mk(4'hA, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // hazard stall while BUSY is ignored
        drv(1, 4'hE, 2'b00, 4'h0, 0, 0, 1, 4'h0, 0, 0);
        run("mulh_c1", mk(4'hA, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        drv(1, 4'hE, 2'b00, 4'hD, 0, 0, 0, 4'h0, 1, 0);
        run("mulh_c2", mk(4'hA, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        run("mulh_c3", mk(4'hA, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        drv(1, 4'hE, 2'b00, 4'hD, 0, 0, 0, 4'h0, 0, 0);
        run("mov_after", mk(4'h1, 0, 0, 1, 0, 0, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
